// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's MEM stage and the data memory responder.
// The core holds its request until ack; busy covers the whole outstanding window.
interface data_mem_responder_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              ack;
    logic              busy;
    logic              req_err;

    modport master (
        output mem_read, mem_write, address, data_in,
        input  data_out, ack, busy, req_err
    );

    modport slave (
        input  mem_read, mem_write, address, data_in,
        output data_out, ack, busy, req_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM that answers single read/write requests after a fixed
// LATENCY, signalling completion with a one-cycle ack while busy stalls the core.
module data_mem_responder #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   bus
);
    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    op_write_reg;
    logic [DEPTH_LOG2-1:0]   addr_reg;
    logic [WORD_W-1:0]       wdata_reg;
    logic [WORD_W-1:0]       data_out_reg;
    logic                    ack_reg;
    logic                    busy_reg;
    logic                    err_reg;

    logic [WORD_W-1:0]       ram [0:DEPTH-1];

    logic                    req;
    logic                    enter_resp;
    logic                    cur_write;
    logic [DEPTH_LOG2-1:0]   cur_addr;
    logic [WORD_W-1:0]       cur_data;

    // Only the low address bits select a word; the rest alias.
    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_addr_alias
            logic unused_addr_bits;
            assign unused_addr_bits = ^bus.address[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    assign req = bus.mem_read | bus.mem_write;

    // With LATENCY=1 the RAM access happens on the accept edge itself, so the
    // live request fields feed the RAM instead of the (not yet loaded) latches.
    always_comb begin
        cur_write  = op_write_reg;
        cur_addr   = addr_reg;
        cur_data   = wdata_reg;
        enter_resp = 1'b0;
        if (state_reg == IDLE) begin
            cur_write = bus.mem_write;
            cur_addr  = bus.address[DEPTH_LOG2-1:0];
            cur_data  = bus.data_in;
        end
        if (!reset) begin
            if (state_reg == IDLE && req && LATENCY == 1)
                enter_resp = 1'b1;
            else if (state_reg == WAIT && cnt_reg == 4'd1)
                enter_resp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_write)
            ram[cur_addr] <= cur_data;
    end

    // Registered RAM read doubles as the held data_out register.
    always_ff @(posedge clk) begin
        if (reset)
            data_out_reg <= '0;
        else if (enter_resp && !cur_write)
            data_out_reg <= ram[cur_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            ack_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 1'b0;
                    if (req) begin
                        op_write_reg <= bus.mem_write;
                        addr_reg     <= bus.address[DEPTH_LOG2-1:0];
                        wdata_reg    <= bus.data_in;
                        cnt_reg      <= LAT_M1;
                        busy_reg     <= 1'b1;
                        if (bus.mem_read && bus.mem_write)
                            err_reg <= 1'b1;
                        if (LATENCY == 1) begin
                            state_reg <= RESP;
                            ack_reg   <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= RESP;
                        ack_reg   <= 1'b1;
                    end
                end
                RESP: begin
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.data_out = data_out_reg;
    assign bus.ack      = ack_reg;
    assign bus.busy     = busy_reg;
    assign bus.req_err  = err_reg;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY 2, 1 and 4 with a scoreboard
// of expected completions checked when each ack appears.
module tb_data_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder_if #(.WORD_W(16), .ADDR_W(16)) bus0 ();
    data_mem_responder_if #(.WORD_W(16), .ADDR_W(16)) bus1 ();
    data_mem_responder_if #(.WORD_W(16), .ADDR_W(16)) bus2 ();

    data_mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(2))
        u_lat2 (.clk(clk), .reset(reset), .bus(bus0));
    data_mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(1))
        u_lat1 (.clk(clk), .reset(reset), .bus(bus1));
    data_mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(4))
        u_lat4 (.clk(clk), .reset(reset), .bus(bus2));

    logic        rd [3];
    logic        wr [3];
    logic [15:0] ad [3];
    logic [15:0] di [3];
    wire  [15:0] dout [3];
    wire         ackw [3];
    wire         busyw [3];
    wire         errw [3];

    assign bus0.mem_read = rd[0]; assign bus0.mem_write = wr[0];
    assign bus0.address  = ad[0]; assign bus0.data_in   = di[0];
    assign bus1.mem_read = rd[1]; assign bus1.mem_write = wr[1];
    assign bus1.address  = ad[1]; assign bus1.data_in   = di[1];
    assign bus2.mem_read = rd[2]; assign bus2.mem_write = wr[2];
    assign bus2.address  = ad[2]; assign bus2.data_in   = di[2];
    assign dout[0] = bus0.data_out; assign ackw[0] = bus0.ack;
    assign busyw[0] = bus0.busy;    assign errw[0] = bus0.req_err;
    assign dout[1] = bus1.data_out; assign ackw[1] = bus1.ack;
    assign busyw[1] = bus1.busy;    assign errw[1] = bus1.req_err;
    assign dout[2] = bus2.data_out; assign ackw[2] = bus2.ack;
    assign busyw[2] = bus2.busy;    assign errw[2] = bus2.req_err;

    typedef struct {
        int          d;
        logic [15:0] data;
        int          lat;
        logic        err;
    } exp_t;

    exp_t        sb [$];
    int          lat_of [3];
    logic [15:0] mem_m [3][256];
    logic [15:0] dout_m [3];
    logic        err_m [3];
    int          t0 [3];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: writes update the model RAM and keep data_out,
    // reads return the model word; a read+write conflict is a sticky error.
    task automatic push_exp(input int d, input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] v);
        exp_t e;
        logic [7:0] idx;
        idx = a[7:0];
        if (w) begin
            mem_m[d][idx] = v;
            e.data = dout_m[d];
        end else begin
            e.data = mem_m[d][idx];
        end
        if (r && w) err_m[d] = 1'b1;
        dout_m[d] = e.data;
        e.d   = d;
        e.lat = lat_of[d];
        e.err = err_m[d];
        sb.push_back(e);
    endtask

    task automatic issue(input int d, input logic r, input logic w, input logic [15:0] a,
                         input logic [15:0] v);
        @(negedge clk);
        rd[d] = r; wr[d] = w; ad[d] = a; di[d] = v;
        push_exp(d, r, w, a, v);
        t0[d] = cyc;
        $display("txn dut%0d rd=%0b wr=%0b addr=%h data=%h", d, r, w, a, v);
    endtask

    task automatic await_ack(input int d, input logic drop, input int nb_init, output int ack_cyc);
        exp_t e;
        int   nb;
        bit   seen;
        nb   = nb_init;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busyw[d]) nb++;
            if (ackw[d]) begin
                seen = 1'b1;
                break;
            end
        end
        ack_cyc = cyc;
        if (!seen) begin
            chk("ack_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk("ack_dut", d, e.d);
            chk("ack_latency", cyc - t0[d], e.lat);
            chk("data_out", dout[d], e.data);
            chk("busy_in_ack", busyw[d], 1'b1);
            chk("req_err", errw[d], e.err);
            chk("busy_cycles", nb, e.lat);
        end
        if (drop) begin
            rd[d] = 1'b0; wr[d] = 1'b0;
            @(negedge clk);
            chk("ack_one_cycle", ackw[d], 1'b0);
            chk("busy_released", busyw[d], 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        lat_of[0] = 2; lat_of[1] = 1; lat_of[2] = 4;
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; di[d] = '0;
            dout_m[d] = '0; err_m[d] = 1'b0; t0[d] = 0;
            for (int k = 0; k < 256; k++) mem_m[d][k] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ack", ackw[d], 1'b0);
            chk("reset_busy", busyw[d], 1'b0);
            chk("reset_data_out", dout[d], 16'h0000);
            chk("reset_req_err", errw[d], 1'b0);
        end

        // Give the words this run reads a known starting value.
        issue(0, 1'b0, 1'b1, 16'h0000, 16'h0000); await_ack(0, 1'b1, 0, a1);
        issue(0, 1'b0, 1'b1, 16'h0003, 16'h0000); await_ack(0, 1'b1, 0, a1);
        issue(0, 1'b0, 1'b1, 16'h0010, 16'h0000); await_ack(0, 1'b1, 0, a1);

        // Write then read back.
        issue(0, 1'b0, 1'b1, 16'h0005, 16'h1234); await_ack(0, 1'b1, 0, a1);
        issue(0, 1'b1, 1'b0, 16'h0005, 16'h0000); await_ack(0, 1'b1, 0, a1);

        // Hold the read past ack: re-accepted in the following IDLE cycle,
        // and an address change after acceptance has no effect.
        issue(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        await_ack(0, 1'b0, 0, a1);
        @(negedge clk);
        chk("hold_idle_ack", ackw[0], 1'b0);
        chk("hold_idle_busy", busyw[0], 1'b0);
        push_exp(0, 1'b1, 1'b0, 16'h0005, 16'h0000);
        t0[0] = cyc;
        @(negedge clk);
        chk("hold_reaccept_busy", busyw[0], 1'b1);
        ad[0] = 16'h0003;
        await_ack(0, 1'b1, 1, a2);
        chk("hold_ack_gap", a2 - a1, lat_of[0] + 1);

        // Read+write conflict with an aliased address.
        issue(0, 1'b1, 1'b1, 16'h0103, 16'hBEEF); await_ack(0, 1'b1, 0, a1);
        issue(0, 1'b1, 1'b0, 16'h0003, 16'h0000); await_ack(0, 1'b1, 0, a1);

        // Reset in the first WAIT cycle aborts a write.
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; ad[0] = 16'h0010; di[0] = 16'hAAAA;
        $display("txn dut0 write 0010=aaaa aborted by reset");
        @(negedge clk);
        chk("abort_busy_before", busyw[0], 1'b1);
        reset = 1'b1; wr[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            dout_m[d] = '0; err_m[d] = 1'b0;
        end
        chk("abort_busy", busyw[0], 1'b0);
        chk("abort_data_out", dout[0], 16'h0000);
        chk("abort_req_err", errw[0], 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_ack", ackw[0], 1'b0);
        end
        issue(0, 1'b1, 1'b0, 16'h0010, 16'h0000); await_ack(0, 1'b1, 0, a1);

        // Idle stability.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_ack", ackw[0], 1'b0);
            chk("idle_busy", busyw[0], 1'b0);
            chk("idle_data_out", dout[0], dout_m[0]);
        end

        // Latency sweep on the LATENCY=1 and LATENCY=4 instances.
        for (int d = 1; d < 3; d++) begin
            issue(d, 1'b0, 1'b1, 16'h0000, 16'h0000); await_ack(d, 1'b1, 0, a1);
            issue(d, 1'b1, 1'b0, 16'h0000, 16'h0000); await_ack(d, 1'b1, 0, a1);
            issue(d, 1'b0, 1'b1, 16'h0101, 16'h00A5); await_ack(d, 1'b1, 0, a1);
            issue(d, 1'b1, 1'b0, 16'h0001, 16'h0000); await_ack(d, 1'b1, 0, a1);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
